// File: rtl/memstream_rewind.sv
// memstream_rewind: single-stream parameter memory streamer.
// A DEPTH x WIDTH memory is streamed cyclically over AXI-Stream through a
// 2-entry output buffer. A runtime config port writes and reads back words,
// and config accesses take priority over stream reads. A rewind pulse
// restarts the stream at word 0.
// Optional feature: define MEMSTREAM_TLAST_EN to add m_axis_0_tlast, which
// marks the word read from address DEPTH-1.
module memstream_rewind #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = "",
    parameter     RAM_STYLE = "auto",
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       config_ce,
    input  logic                       config_we,
    input  logic [ADDR_W-1:0]          config_address,
    input  logic [WIDTH-1:0]           config_d0,
    output logic                       config_rack,
    output logic [WIDTH-1:0]           config_q0,
    input  logic                       rewind,
    input  logic                       m_axis_0_tready,
    output logic                       m_axis_0_tvalid,
    output logic [((WIDTH+7)/8)*8-1:0] m_axis_0_tdata
`ifdef MEMSTREAM_TLAST_EN
    ,
    output logic                       m_axis_0_tlast
`endif
);

    localparam int TDW = ((WIDTH + 7) / 8) * 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
`ifdef MEMSTREAM_TLAST_EN
    // Buffer entries carry the end-of-pass marker above the payload.
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] r_mem [0:DEPTH-1];

    logic [ADDR_W-1:0] r_rptr;
    logic              r_inflight;
    logic [WIDTH-1:0]  r_rdata;
    logic [1:0]        r_occ;
    logic [EW-1:0]     r_buf0;
    logic [EW-1:0]     r_buf1;
    logic              r_rack;
    logic [WIDTH-1:0]  r_cfg_q;
`ifdef MEMSTREAM_TLAST_EN
    logic              r_rlast;
`endif

    logic              w_cfg_in_range;
    logic              w_pop;
    logic              w_push;
    logic [1:0]        w_occ_eff;
    logic              w_issue;
    logic [EW-1:0]     w_push_entry;
    logic [TDW-1:0]    w_tdata;

    // Addresses at or beyond DEPTH are outside the array (non power-of-two DEPTH).
    assign w_cfg_in_range = (32'(config_address) < 32'(DEPTH));
    assign w_pop          = (r_occ != 2'd0) && m_axis_0_tready;
    assign w_push         = r_inflight;
    // Counting this cycle's pop as a freed slot keeps full throughput while
    // still bounding buffered + in-flight words to two.
    assign w_occ_eff      = r_occ - {1'b0, w_pop};
    assign w_issue        = !config_ce && !rewind &&
                            (({1'b0, w_occ_eff} + {2'b00, r_inflight}) < 3'd2);

`ifdef MEMSTREAM_TLAST_EN
    assign w_push_entry   = {r_rlast, r_rdata};
`else
    assign w_push_entry   = r_rdata;
`endif

    // Memory port: config write, otherwise stream read into the output register.
    always_ff @(posedge aclk) begin
        if (config_ce && config_we && w_cfg_in_range) begin
            r_mem[config_address] <= config_d0;
        end
        if (w_issue) begin
            r_rdata <= r_mem[r_rptr];
`ifdef MEMSTREAM_TLAST_EN
            r_rlast <= (r_rptr == LAST_ADDR);
`endif
        end
    end

    // Config readback: one-cycle rack pulse, q0 holds until the next read.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rack  <= 1'b0;
            r_cfg_q <= '0;
        end else begin
            r_rack <= config_ce && !config_we;
            if (config_ce && !config_we) begin
                r_cfg_q <= w_cfg_in_range ? r_mem[config_address] : '0;
            end
        end
    end

    // Stream read pointer and in-flight flag; rewind discards the pending read.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else if (rewind) begin
            r_rptr     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rptr <= (r_rptr == LAST_ADDR) ? '0 : r_rptr + ADDR_W'(1);
            end
        end
    end

    // Two-entry output FIFO; head entry drives the stream outputs.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else if (rewind) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_push_entry;
                    end else begin
                        r_buf0 <= w_push_entry;
                    end
                end
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= w_push_entry;
                    end else begin
                        r_buf1 <= w_push_entry;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

    // Zero-pad the payload up to the byte-aligned stream width.
    always_comb begin
        w_tdata              = '0;
        w_tdata[WIDTH-1:0]   = r_buf0[WIDTH-1:0];
    end

    assign m_axis_0_tvalid = (r_occ != 2'd0);
    assign m_axis_0_tdata  = w_tdata;
    assign config_rack     = r_rack;
    assign config_q0       = r_cfg_q;
`ifdef MEMSTREAM_TLAST_EN
    assign m_axis_0_tlast  = r_buf0[WIDTH];
`endif

endmodule
